// File: rtl/dmem_ctrl.sv
// Data-memory port controller: in-order store queue for retired stores, load/store
// arbitration onto a single D-memory bus with doubleword hazard blocking, squash-aware load tracking.
module dmem_ctrl #(
    parameter int XLEN     = 32,
    parameter int SQ_DEPTH = 4,
    parameter int TAG_W    = 4,
    parameter int SIZE_W   = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              squash,
    input  logic              st_valid,
    input  logic [XLEN-1:0]   st_addr,
    input  logic [XLEN-1:0]   st_data,
    input  logic [SIZE_W-1:0] st_size,
    output logic              st_ready,
    output logic              sq_empty,
    input  logic              ld_valid,
    input  logic [XLEN-1:0]   ld_addr,
    input  logic [SIZE_W-1:0] ld_size,
    output logic              ld_grant,
    output logic              ld_done,
    output logic [XLEN-1:0]   ld_data,
    output logic [1:0]        proc2Dmem_command,
    output logic [XLEN-1:0]   proc2Dmem_addr,
    output logic [63:0]       proc2Dmem_data,
    output logic [SIZE_W-1:0] proc2Dmem_size,
    input  logic [TAG_W-1:0]  Dmem2proc_response,
    input  logic [63:0]       Dmem2proc_data,
    input  logic [TAG_W-1:0]  Dmem2proc_tag
);

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    localparam int PTR_W = $clog2(SQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LD_WAIT  = 2'd1,
        S_LD_DRAIN = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [TAG_W-1:0]      tag_q, tag_d;
    logic [SQ_DEPTH-1:0]   sq_valid_q, sq_valid_d;
    logic [XLEN-1:0]       sq_addr_q [SQ_DEPTH];
    logic [XLEN-1:0]       sq_data_q [SQ_DEPTH];
    logic [SIZE_W-1:0]     sq_size_q [SQ_DEPTH];

    logic                  sq_full;
    logic                  enq;
    logic                  deq;
    logic                  ld_hazard;
    logic                  accepted;
    logic                  tag_hit;
    logic [1:0]            cmd;
    logic                  unused_data_hi;

    // Loads and stores conflict at doubleword granularity.
    function automatic logic same_dword(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        return a[XLEN-1:3] == b[XLEN-1:3];
    endfunction

    assign unused_data_hi = ^Dmem2proc_data[63:XLEN];

    assign sq_full  = (count_q == CNT_W'(SQ_DEPTH));
    assign st_ready = !sq_full;
    assign sq_empty = (count_q == CNT_W'(0));
    assign enq      = st_valid && st_ready;
    assign accepted = (Dmem2proc_response != TAG_W'(0));
    assign tag_hit  = (tag_q != TAG_W'(0)) && (Dmem2proc_tag == tag_q);

    // Load hazard against every live queue entry and a store enqueuing this cycle.
    always_comb begin
        ld_hazard = enq && same_dword(st_addr, ld_addr);
        for (int i = 0; i < SQ_DEPTH; i++) begin
            ld_hazard = ld_hazard | (sq_valid_q[i] && same_dword(sq_addr_q[i], ld_addr));
        end
    end

    // Bus arbitration: a full queue outranks loads; only one transaction outstanding.
    always_comb begin
        cmd = BUS_NONE;
        if (reset || (state_q != S_IDLE)) begin
            cmd = BUS_NONE;
        end else if (sq_full) begin
            cmd = BUS_STORE;
        end else if (ld_valid && !ld_hazard && !squash) begin
            cmd = BUS_LOAD;
        end else if (count_q != CNT_W'(0)) begin
            cmd = BUS_STORE;
        end else begin
            cmd = BUS_NONE;
        end
    end

    // Bus payload mux.
    always_comb begin
        proc2Dmem_addr = {XLEN{1'b0}};
        proc2Dmem_data = 64'd0;
        proc2Dmem_size = {SIZE_W{1'b0}};
        case (cmd)
            BUS_LOAD: begin
                proc2Dmem_addr = ld_addr;
                proc2Dmem_size = ld_size;
            end
            BUS_STORE: begin
                proc2Dmem_addr = sq_addr_q[head_q];
                proc2Dmem_data = 64'(sq_data_q[head_q]);
                proc2Dmem_size = sq_size_q[head_q];
            end
            default: begin
                proc2Dmem_addr = {XLEN{1'b0}};
                proc2Dmem_data = 64'd0;
                proc2Dmem_size = {SIZE_W{1'b0}};
            end
        endcase
    end

    assign proc2Dmem_command = cmd;
    assign ld_grant = (cmd == BUS_LOAD) && accepted;
    assign deq      = (cmd == BUS_STORE) && accepted;
    assign ld_done  = !reset && (state_q == S_LD_WAIT) && tag_hit && !squash;
    assign ld_data  = ld_done ? Dmem2proc_data[XLEN-1:0] : {XLEN{1'b0}};

    // Load tracking FSM next state; a squash with a same-cycle tag match drops the data.
    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        case (state_q)
            S_IDLE: begin
                if (ld_grant) begin
                    state_d = S_LD_WAIT;
                    tag_d   = Dmem2proc_response;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LD_WAIT: begin
                if (tag_hit) begin
                    state_d = S_IDLE;
                    tag_d   = TAG_W'(0);
                end else if (squash) begin
                    state_d = S_LD_DRAIN;
                end else begin
                    state_d = S_LD_WAIT;
                end
            end
            S_LD_DRAIN: begin
                if (tag_hit) begin
                    state_d = S_IDLE;
                    tag_d   = TAG_W'(0);
                end else begin
                    state_d = S_LD_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
                tag_d   = TAG_W'(0);
            end
        endcase
    end

    // Store queue pointer, occupancy and valid-bit next state.
    always_comb begin
        head_d     = deq ? head_q + PTR_W'(1) : head_q;
        tail_d     = enq ? tail_q + PTR_W'(1) : tail_q;
        sq_valid_d = sq_valid_q;
        if (deq) begin
            sq_valid_d[head_q] = 1'b0;
        end else begin
            sq_valid_d = sq_valid_d;
        end
        if (enq) begin
            sq_valid_d[tail_q] = 1'b1;
        end else begin
            sq_valid_d = sq_valid_d;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers and store queue storage.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            head_q     <= PTR_W'(0);
            tail_q     <= PTR_W'(0);
            count_q    <= CNT_W'(0);
            tag_q      <= TAG_W'(0);
            sq_valid_q <= {SQ_DEPTH{1'b0}};
            for (int i = 0; i < SQ_DEPTH; i++) begin
                sq_addr_q[i] <= {XLEN{1'b0}};
                sq_data_q[i] <= {XLEN{1'b0}};
                sq_size_q[i] <= {SIZE_W{1'b0}};
            end
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            tag_q      <= tag_d;
            sq_valid_q <= sq_valid_d;
            if (enq) begin
                sq_addr_q[tail_q] <= st_addr;
                sq_data_q[tail_q] <= st_data;
                sq_size_q[tail_q] <= st_size;
            end
        end
    end

endmodule
